// File: rtl/ternary_alu_wb_stage.sv
// Writeback stage behind ternary_alu: 2-entry skid FIFO toward the register file,
// architectural Z/N/C condition flags and a sticky overflow flag.
package ternary_alu_wb_pkg;
    typedef logic [1:0] trit_t;
    localparam trit_t T_ZERO    = 2'b00;
    localparam trit_t T_POS_ONE = 2'b01;
    localparam trit_t T_NEG_ONE = 2'b10;
endpackage

module ternary_alu_wb_stage
    import ternary_alu_wb_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned RADDR_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  trit_t [WIDTH-1:0]         in_result,
    input  trit_t                     in_carry,
    input  logic                      in_zero,
    input  logic                      in_neg,
    input  logic [RADDR_W-1:0]        in_rd,
    input  logic                      in_wen,
    input  logic                      in_setflags,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output trit_t [WIDTH-1:0]         wb_data,
    output logic [RADDR_W-1:0]        wb_rd,
    output logic                      wb_wen,
    output logic                      flag_z,
    output logic                      flag_n,
    output trit_t                     flag_c,
    output logic                      ovf_sticky,
    input  logic                      clr_ovf
);

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 2;

    typedef trit_t [WIDTH-1:0] word_t;

    word_t              data_q [DEPTH];
    word_t              data_d [DEPTH];
    logic [RADDR_W-1:0] rd_q   [DEPTH];
    logic [RADDR_W-1:0] rd_d   [DEPTH];
    logic [DEPTH-1:0]   wen_q, wen_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               in_ready_q, in_ready_d;
    logic               wb_valid_q, wb_valid_d;
    word_t              wb_data_q, wb_data_d;
    logic [RADDR_W-1:0] wb_rd_q, wb_rd_d;
    logic               wb_wen_q, wb_wen_d;
    logic               flag_z_q, flag_z_d;
    logic               flag_n_q, flag_n_d;
    trit_t              flag_c_q, flag_c_d;
    logic               ovf_q, ovf_d;
    logic               push_c, pop_c, ovf_set_c;

    assign push_c    = in_valid & in_ready_q;
    assign pop_c     = wb_valid_q & wb_ready;
    assign ovf_set_c = push_c & in_setflags & (in_carry != T_ZERO);

    // FIFO bookkeeping; the head view is registered from the next-state storage
    always_comb begin
        data_d   = data_q;
        rd_d     = rd_q;
        wen_d    = wen_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (push_c) begin
            data_d[wr_ptr_q] = in_result;
            rd_d[wr_ptr_q]   = in_rd;
            wen_d[wr_ptr_q]  = in_wen;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop_c) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        in_ready_d = (count_d < CNT_W'(DEPTH));
        wb_valid_d = (count_d != '0);
        wb_data_d  = data_d[rd_ptr_d];
        wb_rd_d    = rd_d[rd_ptr_d];
        wb_wen_d   = wen_d[rd_ptr_d];
    end

    // Condition flags follow accepted instructions in issue order; set beats clear
    always_comb begin
        flag_z_d = flag_z_q;
        flag_n_d = flag_n_q;
        flag_c_d = flag_c_q;
        ovf_d    = ovf_q;

        if (push_c && in_setflags) begin
            flag_z_d = in_zero;
            flag_n_d = in_neg;
            flag_c_d = in_carry;
        end
        if (ovf_set_c) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
                rd_q[i]   <= '0;
            end
            wen_q      <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_wen_q   <= 1'b0;
            flag_z_q   <= 1'b0;
            flag_n_q   <= 1'b0;
            flag_c_q   <= T_ZERO;
            ovf_q      <= 1'b0;
        end else begin
            data_q     <= data_d;
            rd_q       <= rd_d;
            wen_q      <= wen_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_wen_q   <= wb_wen_d;
            flag_z_q   <= flag_z_d;
            flag_n_q   <= flag_n_d;
            flag_c_q   <= flag_c_d;
            ovf_q      <= ovf_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign wb_valid   = wb_valid_q;
    assign wb_data    = wb_data_q;
    assign wb_rd      = wb_rd_q;
    assign wb_wen     = wb_wen_q;
    assign flag_z     = flag_z_q;
    assign flag_n     = flag_n_q;
    assign flag_c     = flag_c_q;
    assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_ternary_alu_wb_stage.sv
// Bench for ternary_alu_wb_stage: queue scoreboard plus flag model, directed
// scenarios followed by randomized traffic with random backpressure.
module tb_ternary_alu_wb_stage;
    import ternary_alu_wb_pkg::*;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned RADDR_W = 4;

    typedef trit_t [WIDTH-1:0] word_t;
    typedef struct {
        word_t              data;
        logic [RADDR_W-1:0] rd;
        logic               wen;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid, in_ready;
    word_t              in_result;
    trit_t              in_carry;
    logic               in_zero, in_neg;
    logic [RADDR_W-1:0] in_rd;
    logic               in_wen, in_setflags;
    logic               wb_valid, wb_ready;
    word_t              wb_data;
    logic [RADDR_W-1:0] wb_rd;
    logic               wb_wen;
    logic               flag_z, flag_n;
    trit_t              flag_c;
    logic               ovf_sticky, clr_ovf;

    ternary_alu_wb_stage #(.WIDTH(WIDTH), .RADDR_W(RADDR_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_carry(in_carry),
        .in_zero(in_zero), .in_neg(in_neg),
        .in_rd(in_rd), .in_wen(in_wen), .in_setflags(in_setflags),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data), .wb_rd(wb_rd), .wb_wen(wb_wen),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
        .ovf_sticky(ovf_sticky), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];
    logic armed = 1'b0;
    logic m_z = 1'b0, m_n = 1'b0, m_o = 1'b0;
    trit_t m_c = T_ZERO;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Integer to balanced-ternary word, least significant trit first
    function automatic word_t to_trits(input int v);
        word_t w = '0;
        int r;
        for (int i = 0; i < int'(WIDTH); i++) begin
            r = v % 3;
            if (r < 0) r += 3;
            if (r == 0) begin w[i] = T_ZERO; v = v / 3; end
            else if (r == 1) begin w[i] = T_POS_ONE; v = (v - 1) / 3; end
            else begin w[i] = T_NEG_ONE; v = (v + 1) / 3; end
        end
        return w;
    endfunction

    function automatic trit_t rand_trit();
        case ($urandom_range(0, 2))
            0:       return T_ZERO;
            1:       return T_POS_ONE;
            default: return T_NEG_ONE;
        endcase
    endfunction

    function automatic word_t rand_word();
        word_t w;
        for (int i = 0; i < int'(WIDTH); i++) w[i] = rand_trit();
        return w;
    endfunction

    // in_ready may only be high once a clock edge has been seen outside reset
    task automatic arm_tracker();
        forever begin
            @(posedge clk);
            armed = !rst;
        end
    endtask

    // Monitor: compares DUT against the model each cycle, then commits this cycle's handshakes
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                m_z = 1'b0; m_n = 1'b0; m_c = T_ZERO; m_o = 1'b0;
            end else begin
                chk("in_ready", 64'(in_ready), 64'(armed && sb.size() < 2));
                chk("wb_valid", 64'(wb_valid), 64'(sb.size() != 0));
                if (wb_valid && sb.size() != 0) begin
                    chk("wb_data", 64'(wb_data), 64'(sb[0].data));
                    chk("wb_rd",   64'(wb_rd),   64'(sb[0].rd));
                    chk("wb_wen",  64'(wb_wen),  64'(sb[0].wen));
                    if (wb_ready) void'(sb.pop_front());
                end
                chk("flag_z", 64'(flag_z), 64'(m_z));
                chk("flag_n", 64'(flag_n), 64'(m_n));
                chk("flag_c", 64'(flag_c), 64'(m_c));
                chk("ovf_sticky", 64'(ovf_sticky), 64'(m_o));
                if (in_valid && in_ready) begin
                    e.data = in_result; e.rd = in_rd; e.wen = in_wen;
                    sb.push_back(e);
                    if (in_setflags) begin
                        m_z = in_zero; m_n = in_neg; m_c = in_carry;
                    end
                end
                if (in_valid && in_ready && in_setflags && in_carry != T_ZERO) m_o = 1'b1;
                else if (clr_ovf) m_o = 1'b0;
            end
        end
    endtask

    // Offers one entry and holds it until accepted; returns just after the accepting edge
    task automatic push(input word_t d, input logic [RADDR_W-1:0] rd, input logic wen,
                        input logic sf, input trit_t c, input logic z, input logic n,
                        input logic clr);
        int w = 0;
        in_valid = 1'b1; in_result = d; in_rd = rd; in_wen = wen;
        in_setflags = sf; in_carry = c; in_zero = z; in_neg = n; clr_ovf = clr;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("push_accept_timeout", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0; clr_ovf = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_result = '0; in_carry = T_ZERO; in_zero = 1'b0; in_neg = 1'b0;
        in_rd = '0; in_wen = 1'b0; in_setflags = 1'b0; wb_ready = 1'b1; clr_ovf = 1'b0;
        fork
            monitor();
            arm_tracker();
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_wb_valid", 64'(wb_valid), 64'(0));
        chk("rst_wb_data",  64'(wb_data),  64'(0));
        rst = 1'b0;

        // Single push: visible the cycle after acceptance
        push(to_trits(15), 4'd1, 1'b1, 1'b1, T_ZERO, 1'b0, 1'b0, 1'b0);
        chk("t1_valid", 64'(wb_valid), 64'(1));
        chk("t1_data",  64'(wb_data),  64'(to_trits(15)));
        @(posedge clk); #1;

        // Backpressure: third entry waits upstream until the sink drains
        wb_ready = 1'b0;
        push(to_trits(10), 4'd2, 1'b1, 1'b0, T_ZERO, 1'b0, 1'b0, 1'b0);
        push(to_trits(-5), 4'd3, 1'b0, 1'b0, T_ZERO, 1'b0, 1'b0, 1'b0);
        fork
            push(to_trits(7), 4'd4, 1'b1, 1'b0, T_ZERO, 1'b0, 1'b0, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("t2_full_ready", 64'(in_ready), 64'(0));
                chk("t2_head", 64'(wb_data), 64'(to_trits(10)));
                wb_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk); #1;

        // Steady push+pop with one entry resident
        wb_ready = 1'b0;
        push(to_trits(100), 4'd5, 1'b1, 1'b0, T_ZERO, 1'b0, 1'b0, 1'b0);
        wb_ready = 1'b1;
        for (int i = 0; i < 8; i++)
            push(to_trits(i * 13 - 40), RADDR_W'(i), 1'b1, 1'b0, T_ZERO, 1'b0, 1'b0, 1'b0);
        chk("t3_ready", 64'(in_ready), 64'(1));
        repeat (3) @(posedge clk); #1;

        // Overflow set wins over a same-cycle clear; clear alone then works
        push(to_trits(1), 4'd6, 1'b1, 1'b1, T_POS_ONE, 1'b0, 1'b0, 1'b1);
        chk("t4_ovf_set", 64'(ovf_sticky), 64'(1));
        chk("t4_flag_c",  64'(flag_c), 64'(T_POS_ONE));
        clr_ovf = 1'b1;
        @(posedge clk); #1;
        clr_ovf = 1'b0;
        chk("t4_ovf_clr", 64'(ovf_sticky), 64'(0));

        // setflags gating
        push(to_trits(-3), 4'd7, 1'b1, 1'b0, T_NEG_ONE, 1'b0, 1'b1, 1'b0);
        chk("t5_n_hold", 64'(flag_n), 64'(0));
        push(to_trits(0), 4'd8, 1'b1, 1'b1, T_ZERO, 1'b1, 1'b0, 1'b0);
        chk("t5_z", 64'(flag_z), 64'(1));
        chk("t5_n", 64'(flag_n), 64'(0));
        repeat (3) @(posedge clk); #1;

        // Asynchronous reset with the FIFO full and all flags set
        wb_ready = 1'b0;
        push(to_trits(20), 4'd9, 1'b1, 1'b1, T_NEG_ONE, 1'b1, 1'b1, 1'b0);
        push(to_trits(21), 4'd10, 1'b1, 1'b1, T_NEG_ONE, 1'b1, 1'b1, 1'b0);
        chk("t6_pre_ovf", 64'(ovf_sticky), 64'(1));
        #2 rst = 1'b1;
        #1;
        chk("t6_wb_valid", 64'(wb_valid), 64'(0));
        chk("t6_in_ready", 64'(in_ready), 64'(0));
        chk("t6_flags", 64'({flag_z, flag_n, flag_c, ovf_sticky}), 64'(0));
        chk("t6_wb_data", 64'(wb_data), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        wb_ready = 1'b1;
        push(to_trits(42), 4'd11, 1'b1, 1'b0, T_ZERO, 1'b0, 1'b0, 1'b0);
        chk("t6_alone", 64'(wb_data), 64'(to_trits(42)));
        repeat (3) @(posedge clk); #1;

        // Random traffic and backpressure
        for (int i = 0; i < 600; i++) begin
            in_valid    = 1'($urandom_range(0, 1));
            wb_ready    = ($urandom_range(0, 3) != 0);
            in_result   = rand_word();
            in_carry    = rand_trit();
            in_zero     = 1'($urandom_range(0, 1));
            in_neg      = 1'($urandom_range(0, 1));
            in_rd       = RADDR_W'($urandom_range(0, 15));
            in_wen      = 1'($urandom_range(0, 1));
            in_setflags = 1'($urandom_range(0, 1));
            clr_ovf     = ($urandom_range(0, 7) == 0);
            @(posedge clk); #1;
        end

        in_valid = 1'b0; clr_ovf = 1'b0; wb_ready = 1'b1;
        for (int w = 0; w < 20 && wb_valid; w++) begin
            @(posedge clk); #1;
        end
        @(negedge clk); #1;
        chk("drain_valid", 64'(wb_valid), 64'(0));
        chk("drain_sb", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
